// File: rtl/pe_psum_drain.sv
// Drains one PE column's psum shift chain tail-first, requantizes each psum and hands it downstream.
// Latency: first o_out_valid one cycle after entering DRAIN, then one word per cycle when o_out_ready stays high.
// Backpressure: a held word (valid & ~ready) freezes the chain; pe_shift and the write enables drop until it leaves.
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_start                        one-cycle pulse to begin a drain (ignored unless idle)
//   i_bank_sel, i_quant_shift,
//   i_if_relu                      drain configuration, latched at start
//   i_psum_tail                    psum_out of the last PE in the column
//   o_pe_shift, o_pe_wea_reg1/2,
//   o_pe_sel_pe_reg                column chain controls
//   o_out_valid/i_out_ready,
//   o_out_data, o_out_idx          activation output handshake; idx 0 is the tail PE
//   o_busy, o_done                 drain in progress / one-cycle completion pulse
module pe_psum_drain #(
    parameter int PSUM_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_bank_sel,
    input  logic [4:0]            i_quant_shift,
    input  logic                  i_if_relu,
    input  logic [PSUM_WIDTH-1:0] i_psum_tail,
    output logic                  o_pe_shift,
    output logic                  o_pe_wea_reg1,
    output logic                  o_pe_wea_reg2,
    output logic                  o_pe_sel_pe_reg,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [IDX_WIDTH-1:0]  o_out_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int SAT_MAX_I = (1 << (DATA_WIDTH - 1)) - 1;

    logic [1:0]            r_state;
    logic [IDX_WIDTH-1:0]  r_cnt;
    logic                  r_bank;
    logic [4:0]            r_qs;
    logic                  r_relu;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IDX_WIDTH-1:0]  r_out_idx;
    logic                  r_done;

    logic w_adv;
    logic w_shift;
    logic w_last;
    logic w_accept;

    // Chain advances whenever the output register is free or being emptied this cycle.
    assign w_adv    = ~r_out_valid | i_out_ready;
    assign w_shift  = (r_state == S_DRAIN) & w_adv;
    assign w_last   = (r_cnt == IDX_WIDTH'(ROWS - 1));
    assign w_accept = r_out_valid & i_out_ready;

    // Requantization: one extra bit of headroom keeps the rounding add from overflowing.
    logic signed [PSUM_WIDTH:0] w_ext;
    logic signed [PSUM_WIDTH:0] w_rnd;
    logic signed [PSUM_WIDTH:0] w_sum;
    logic signed [PSUM_WIDTH:0] w_shr;
    logic [DATA_WIDTH-1:0]      w_q;

    assign w_ext = {i_psum_tail[PSUM_WIDTH-1], i_psum_tail};
    // Half-LSB rounding constant 2^(qs-1); shifting the 1 up by qs then down by one yields 0 for qs=0.
    assign w_rnd = $signed(({{PSUM_WIDTH{1'b0}}, 1'b1} << r_qs) >> 1);
    assign w_sum = w_ext + w_rnd;
    assign w_shr = w_sum >>> r_qs;

    always_comb begin
        w_q = w_shr[DATA_WIDTH-1:0];
        if (r_relu && w_shr[PSUM_WIDTH]) begin
            w_q = '0;
        end else if (w_shr > (PSUM_WIDTH+1)'(SAT_MAX_I)) begin
            w_q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shr < (PSUM_WIDTH+1)'(-SAT_MAX_I - 1)) begin
            w_q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bank      <= 1'b0;
            r_qs        <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bank  <= i_bank_sel;
                        r_qs    <= i_quant_shift;
                        r_relu  <= i_if_relu;
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_adv) begin
                        r_out_data  <= w_q;
                        r_out_idx   <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_cnt       <= r_cnt + IDX_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pe_shift      = w_shift;
    assign o_pe_wea_reg1   = w_shift & ~r_bank;
    assign o_pe_wea_reg2   = w_shift & r_bank;
    assign o_pe_sel_pe_reg = r_bank;
    assign o_out_valid     = r_out_valid;
    assign o_out_data      = r_out_data;
    assign o_out_idx       = r_out_idx;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;

endmodule

// File: tb/tb_pe_psum_drain.sv
// Self-checking bench for pe_psum_drain: a behavioural PE column feeds the tail, a scoreboard checks words.
// Latency: checks first-valid, one-word-per-cycle throughput and done one cycle after the final accept.
// Backpressure: out_ready driven constant, patterned or random; stalls must freeze the chain and the output.
module tb_pe_psum_drain;
    localparam int PW   = 32;
    localparam int DW   = 8;
    localparam int ROWS = 8;
    localparam int IW   = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          bank_sel;
    logic [4:0]    quant_shift;
    logic          if_relu;
    logic [PW-1:0] psum_tail;
    logic          pe_shift;
    logic          pe_wea_reg1;
    logic          pe_wea_reg2;
    logic          pe_sel_pe_reg;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          busy;
    logic          done;

    pe_psum_drain #(.PSUM_WIDTH(PW), .DATA_WIDTH(DW), .ROWS(ROWS), .IDX_WIDTH(IW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_bank_sel(bank_sel),
        .i_quant_shift(quant_shift), .i_if_relu(if_relu), .i_psum_tail(psum_tail),
        .o_pe_shift(pe_shift), .o_pe_wea_reg1(pe_wea_reg1), .o_pe_wea_reg2(pe_wea_reg2),
        .o_pe_sel_pe_reg(pe_sel_pe_reg), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_idx(out_idx), .o_busy(busy), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [PW-1:0] col   [ROWS];
    logic signed [PW-1:0] chain [ROWS];
    int exp_q[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference requantizer straight from the arithmetic definition, in 64-bit integers.
    function automatic int q_ref(input longint p, input int qs, input bit relu);
        longint r;
        r = p;
        if (qs > 0) r = r + (longint'(1) << (qs - 1));
        r = r >>> qs;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < ROWS; i++) begin
            case ($urandom_range(0, 2))
                0:       col[i] = $signed($urandom);
                1:       col[i] = $signed($urandom_range(0, 8191)) - 4096;
                default: col[i] = $signed($urandom_range(0, 2097151)) - 1048576;
            endcase
        end
    endtask

    // Behavioural column: a shift pulse moves every PE one step toward the tail.
    task automatic edge_and_shift(input bit shift_seen);
        @(posedge clk);
        #1;
        if (shift_seen) begin
            for (int i = 0; i < ROWS - 1; i++) chain[i] = chain[i + 1];
            chain[ROWS - 1] = 0;
        end
        psum_tail = chain[0];
    endtask

    // rmode: 0 = ready always high, 1 = pattern 1,0,0,..., 2 = random.
    task automatic run_drain(input int qs, input bit relu, input bit bank, input int rmode,
                             input int mid_start_cyc, input bit final_start, input int abort_after);
        int  shifts;
        int  accepts;
        int  cyc;
        int  last_acc;
        bit  done_seen;
        bit  prev_valid;
        bit  prev_ready;
        logic [DW-1:0] prev_data;
        logic [IW-1:0] prev_idx;
        bit  sh;

        exp_q.delete();
        for (int i = 0; i < ROWS; i++) exp_q.push_back(q_ref(longint'(col[i]), qs, relu));
        for (int i = 0; i < ROWS; i++) chain[i] = col[i];
        psum_tail   = chain[0];
        quant_shift = 5'(qs);
        if_relu     = relu;
        bank_sel    = bank;
        start       = 1'b1;
        out_ready   = 1'b0;
        #1;
        edge_and_shift(1'b0);
        start = 1'b0;
        // Scramble config after start: the latched copy must be used.
        quant_shift = 5'($urandom);
        if_relu     = ~relu;
        bank_sel    = ~bank;

        shifts = 0; accepts = 0; cyc = 0; last_acc = -10; done_seen = 0;
        prev_valid = 0; prev_ready = 0; prev_data = '0; prev_idx = '0;
        while (!done_seen && cyc < 300) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == mid_start_cyc) ||
                    (final_start && out_valid && int'(out_idx) == ROWS - 1 && out_ready);
            #1;
            if (cyc == 0) begin
                chk("first_cycle_valid", longint'(out_valid), 0);
                chk("first_cycle_shift", longint'(pe_shift), 1);
            end
            if (done) begin
                chk("done_timing", cyc, last_acc + 1);
                chk("busy_at_done", longint'(busy), 0);
                done_seen = 1;
            end else begin
                chk("busy", longint'(busy), 1);
            end
            chk("sel_pe_reg", longint'(pe_sel_pe_reg), longint'(bank));
            chk("wea_reg1", longint'(pe_wea_reg1), longint'(pe_shift & ~bank));
            chk("wea_reg2", longint'(pe_wea_reg2), longint'(pe_shift & bank));
            if (out_valid && !out_ready) chk("stall_no_shift", longint'(pe_shift), 0);
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", longint'(out_valid), 1);
                chk("stall_data", longint'(out_data), longint'(prev_data));
                chk("stall_idx", longint'(out_idx), longint'(prev_idx));
            end
            if (pe_shift) shifts++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", accepts + 1, ROWS);
                end else begin
                    chk("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
                    chk("out_idx", longint'(out_idx), accepts);
                end
                accepts++;
                last_acc = cyc;
            end
            prev_valid = out_valid; prev_ready = out_ready;
            prev_data  = out_data;  prev_idx   = out_idx;
            if (abort_after >= 0 && accepts == abort_after) begin
                start = 1'b0;
                return;
            end
            sh = pe_shift;
            edge_and_shift(sh);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", longint'(done_seen), 1);
        chk("shift_count", shifts, ROWS);
        chk("word_count", accepts, ROWS);
        if (final_start) begin
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("restart_ignored_busy", longint'(busy), 0);
                chk("restart_ignored_shift", longint'(pe_shift), 0);
                edge_and_shift(1'b0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_shift"}, longint'(pe_shift), 0);
        chk({tag, "_wea1"}, longint'(pe_wea_reg1), 0);
        chk({tag, "_wea2"}, longint'(pe_wea_reg2), 0);
        chk({tag, "_sel"}, longint'(pe_sel_pe_reg), 0);
        chk({tag, "_valid"}, longint'(out_valid), 0);
        chk({tag, "_data"}, longint'(out_data), 0);
        chk({tag, "_idx"}, longint'(out_idx), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bank_sel = 1'b0; quant_shift = '0; if_relu = 1'b0;
        psum_tail = '0; out_ready = 1'b0;
        for (int i = 0; i < ROWS; i++) chain[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        edge_and_shift(1'b0);

        // Ramp column, pass-through quantization.
        for (int i = 0; i < ROWS; i++) col[i] = 10 * i;
        run_drain(0, 1'b0, 1'b0, 0, -1, 1'b0, -1);

        // Rounding cases.
        fill_random(); col[0] = 384;
        run_drain(4, 1'b0, 1'b0, 0, -1, 1'b0, -1);
        fill_random(); col[0] = -23;
        run_drain(1, 1'b0, 1'b0, 2, -1, 1'b0, -1);

        // Saturation, then ReLU on the same values with bank 1 and a mid-drain start.
        fill_random(); col[0] = 100000; col[1] = -100000;
        run_drain(2, 1'b0, 1'b0, 1, -1, 1'b0, -1);
        run_drain(2, 1'b1, 1'b1, 1, 3, 1'b0, -1);

        // Start coincident with the final accept is ignored.
        fill_random();
        run_drain(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, 2, -1, 1'b1, -1);

        // Reset after three words, then a fresh full drain from idx 0.
        fill_random();
        run_drain(3, 1'b0, 1'b1, 0, -1, 1'b0, 3);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        edge_and_shift(1'b0);
        fill_random();
        run_drain(3, 1'b0, 1'b0, 0, -1, 1'b0, -1);

        // Random drains.
        for (int t = 0; t < 5; t++) begin
            fill_random();
            run_drain(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 12)), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_psum_drain.md
Name: pe_psum_drain

Overview:
- Read-side controller for one PE column's partial-sum shift chain.
- After accumulation completes, it shifts the column out through the chain tail, one PE per transfer, by driving each PE's shift and register-write controls.
- Each captured psum is requantized (rounding arithmetic right shift, optional ReLU, saturation) to an activation word.
- Results go to the output/activation buffer over a valid/ready handshake, with backpressure stalling the chain.

Parameters:
- PSUM_WIDTH, 32, width of PE partial sums
- DATA_WIDTH, 8, width of output activation, signed two's complement
- ROWS, 8, number of PEs in the column chain (≥2)
- IDX_WIDTH, 3, width of out_idx; ≥ clog2(ROWS)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse to begin draining; ignored unless idle
- bank_sel  in  1  0 = drain psum_out1 bank, 1 = drain psum_out2 bank; latched at start
- quant_shift  in  5  right-shift amount, 0..31; latched at start
- if_relu  in  1  clamp negatives to 0; latched at start
- psum_tail  in  PSUM_WIDTH  psum_out of the last PE in the column
- pe_shift  out  1  shift control to every PE in the column
- pe_wea_reg1  out  1  write enable, bank 1
- pe_wea_reg2  out  1  write enable, bank 2
- pe_sel_pe_reg  out  1  PE output-mux select; equals latched bank_sel
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  requantized activation
- out_idx  out  IDX_WIDTH  row index of out_data; 0 = tail PE (first out)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the last word is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; latched config 0.
- FSM states are IDLE, DRAIN, FLUSH.
- IDLE:
  - start=1 latches config, clears cnt, and moves to DRAIN next cycle; busy=1 from that cycle.
- DRAIN:
  - adv = ~out_valid | out_ready.
  - When adv=1 in the same cycle:
    - capture Q(psum_tail) into out_data and cnt into out_idx; set out_valid=1 next cycle;
    - assert pe_shift=1 and the write enable for the latched bank (pe_wea_reg1 if bank_sel=0, else pe_wea_reg2);
    - increment cnt.
  - When adv=0: pe_shift=0 and both write enables are 0, so the chain holds.
  - Capture of cnt==ROWS-1 moves to FLUSH.
  - Exactly ROWS shift pulses per drain, never more.
- FLUSH:
  - No shift or write enables.
  - Wait for out_ready with out_valid=1; on that accept, out_valid=0, done=1 for one cycle, busy=0, return to IDLE.
- Handshake rules:
  - A word transfers when out_valid & out_ready.
  - out_data and out_idx are stable while out_valid=1 and out_ready=0.
  - Throughput is one word per cycle with out_ready held high.
  - First out_valid appears one cycle after entering DRAIN.
- Q(p) arithmetic, signed:
  - r = (p + (qs≠0 ? 2^(qs-1) : 0)) >>> qs, computed in PSUM_WIDTH+1 bits so no overflow.
  - If latched if_relu and r<0, then r=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Boundary and corner cases:
  - start while busy or in FLUSH is ignored.
  - Config changes after start have no effect until the next start.
  - Asynchronous reset mid-drain:
    - immediately deasserts pe_shift, write enables, out_valid and busy; returns to IDLE;
    - a partially drained column is not recovered.
  - out_ready high while out_valid=0 has no effect.
  - start and a final accept in the same cycle: the start is ignored; it must be reissued after done.

Test Plan:
- ROWS=8, psum chain tail-first 0,10,20..70, qs=0, relu=0, out_ready=1 → 8 pe_shift pulses on consecutive cycles; out_data 0,10..70 with idx 0..7; done one cycle after the last accept.
- psum_tail=0x00000180 (384), qs=4 → (384+8)>>>4=24; psum=-23, qs=1 → (-23+1)>>>1=-11.
- psum=100000, qs=2 → 127; psum=-100000 → -128; same value with relu=1 → 0.
- out_ready toggles 1,0,0,1,... → no pe_shift in cycles with out_valid=1 and out_ready=0; out_data stable; all 8 words delivered in order with no duplicates; exactly 8 shift pulses total.
- bank_sel=1 → only pe_wea_reg2 pulses and pe_sel_pe_reg=1; bank_sel=0 → only pe_wea_reg1 and pe_sel_pe_reg=0; start asserted mid-drain → ignored.
- Assert reset after 3 words → outputs 0 in the same cycle; a new start drains a full 8 words from idx 0.
